uart_tx_buffered: RTL and testbench

- Byte-serial UART transmitter with a small transmit FIFO. It is the far end of the SRAM controller's tx_enable/tx_valid/tx_ready/tx_data_in interface and drives the chip's serial TX pin.
- Accepts bytes from the controller, including four-byte read-response bursts, and serialises them as 8N1 frames, LSB first.
- Frames go out back to back with no idle gap while data is queued.

---
 rtl/uart_tx_buffered.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: small byte FIFO feeding a back-to-back frame serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_buffered #(
  parameter int unsigned CLK_DIV    = 87,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_enable,
  input  logic       tx_valid,
  input  logic [7:0] tx_data_in,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [CW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  state_t        state;
  logic          push, pop, to_idle;

  // Readiness is judged on the count at the start of the cycle, so a full FIFO never takes a byte.
  assign tx_ready = tx_enable & (count < DEPTH);
  assign push     = tx_valid & tx_ready;

  always_comb begin
    pop     = 1'b0;
    to_idle = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) pop = 1'b1;
        else             to_idle = 1'b1;
      end
      STOP: begin
        if (baud == '0) begin
          if (count != '0) pop = 1'b1;
          else             to_idle = 1'b1;
        end
      end
      START, DATA: ;
`ifdef UART_TX_PARITY_EN
      PARITY: ;
`endif
      default: to_idle = 1'b1;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      // Busy tracks the post-edge state so it drops on the same edge the last stop bit ends.
      tx_busy <= !(to_idle && (count_next == '0));
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= RELOAD;
            txd   <= 1'b0;
            state <= START;
          end else begin
            txd <= 1'b1;
          end
        end
        START: begin
          if (baud == '0) begin
            baud    <= RELOAD;
            bit_cnt <= '0;
            txd     <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud - CW'(1);
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud <= RELOAD;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd   <= ^shift;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd     <= shift[bit_cnt + 3'd1];
            end
          end else begin
            baud <= baud - CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud == '0) begin
            baud  <= RELOAD;
            txd   <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud - CW'(1);
          end
        end
`endif
        STOP: begin
          if (baud == '0) begin
            // Chain straight into the next start bit when data is waiting: no idle cycle.
            if (pop) begin
              shift <= mem[rd_ptr];
              baud  <= RELOAD;
              txd   <= 1'b0;
              state <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud - CW'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: line decoder plus queue-based model of accepted bytes.
module tb_uart_tx_buffered;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_enable, tx_valid;
  logic [7:0] tx_data_in;
  logic       tx_ready, txd, tx_busy;

  uart_tx_buffered #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .tx_valid(tx_valid),
    .tx_data_in(tx_data_in), .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, last_edge = 0;
  int started = 0, acc = 0, line_err = 0, ready_err = 0;
  logic [7:0] exp_q[$], rx_q[$];
  logic       par_q[$];
  int         starts_q[$];
  bit         mon_active = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] mon_byte;
  logic       mon_par;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for bit slot idx of a frame carrying b.
  function automatic logic fbit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_byte   = '0;
        mon_par    = 1'b0;
        started++;
        starts_q.push_back(cyc);
      end
      if (mon_active) begin
        int k, idx;
        k   = rx_q.size();
        idx = mon_cyc / DIV;
        if (k < exp_q.size()) begin
          if (txd !== fbit(exp_q[k], idx)) line_err++;
        end else begin
          line_err++;
        end
        if (mon_cyc % DIV == DIV / 2) begin
          if (idx >= 1 && idx <= 8) mon_byte[idx-1] = txd;
          if (idx == 9) mon_par = txd;
        end
        if (mon_cyc == NB * DIV - 1) begin
          rx_q.push_back(mon_byte);
          par_q.push_back(mon_par);
          mon_active = 1'b0;
        end else begin
          mon_cyc++;
        end
      end
    end
  end

  // Entered and left just after a falling edge; the byte is accepted by the model
  // only when the model's own occupancy says there is room.
  task automatic step(input logic v, input logic [7:0] d, output logic rdy);
    logic er;
    tx_valid   = v;
    tx_data_in = d;
    #1;
    er  = tx_enable && ((acc - started) < DEPTH);
    rdy = tx_ready;
    if (tx_ready !== er) ready_err++;
    if (v && er) begin
      exp_q.push_back(d);
      acc++;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    last_edge = cyc;
  endtask

  task automatic wait_idle(output int fall, output bit ok);
    logic er;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      er = tx_enable && ((acc - started) < DEPTH);
      if (tx_ready !== er) ready_err++;
      @(negedge clk);
      #1;
    end
    fall = cyc;
  endtask

  task automatic clear_model;
    exp_q.delete(); rx_q.delete(); par_q.delete(); starts_q.delete();
    line_err = 0; ready_err = 0;
  endtask

  task automatic test_reset;
    tx_valid = 1'b0; tx_data_in = '0; tx_enable = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else n_pass++;
    n_checks++; if (tx_ready !== 1'b0) $display("FAIL reset_ready_en0: got %b want 0", tx_ready); else n_pass++;
    tx_enable = 1'b1;
    #1;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready_en1: got %b want 1", tx_ready); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    repeat (3) begin
      logic r;
      step(1'b0, 8'h00, r);
    end
    n_checks++; if (txd !== 1'b1 || tx_busy !== 1'b0) $display("FAIL post_reset_idle: txd=%b busy=%b want 1/0", txd, tx_busy); else n_pass++;
  endtask

  task automatic test_single;
    logic r; int e0, fall; bit ok;
    clear_model();
    step(1'b1, 8'hA5, r);
    e0 = last_edge;
    step(1'b0, 8'h00, r);
    wait_idle(fall, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL single_drain: busy never fell"); else n_pass++;
    n_checks++; if (starts_q.size() != 1 || starts_q[0] != e0 + 1) $display("FAIL single_latency: frames=%0d start=%0d want 1 frame at %0d", starts_q.size(), (starts_q.size() > 0) ? starts_q[0] : -1, e0 + 1); else n_pass++;
    n_checks++; if (starts_q.size() > 0 && fall - starts_q[0] != NB * DIV) $display("FAIL single_busy_fall: got %0d want %0d", fall - starts_q[0], NB * DIV); else n_pass++;
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL single_data: got %0d bytes first=%h want A5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); else n_pass++;
    n_checks++; if (line_err != 0) $display("FAIL single_line: %0d bad bit cycles want 0", line_err); else n_pass++;
    n_checks++; if (ready_err != 0) $display("FAIL single_ready: %0d bad cycles want 0", ready_err); else n_pass++;
  endtask

  task automatic test_burst;
    logic [7:0] b [4];
    logic r; int a0, fall; bit ok;
    b[0] = 8'h78; b[1] = 8'h56; b[2] = 8'h34; b[3] = 8'h12;
    clear_model();
    a0 = acc;
    for (int i = 0; i < 4; i++) step(1'b1, b[i], r);
    step(1'b0, 8'h00, r);
    wait_idle(fall, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL burst_drain: busy never fell"); else n_pass++;
    n_checks++; if (acc - a0 != 4) $display("FAIL burst_accept: got %0d want 4", acc - a0); else n_pass++;
    n_checks++; if (starts_q.size() != 4) $display("FAIL burst_frames: got %0d want 4", starts_q.size()); else n_pass++;
    for (int i = 0; i + 1 < starts_q.size(); i++) begin
      n_checks++; if (starts_q[i+1] - starts_q[i] != NB * DIV) $display("FAIL burst_gap%0d: got %0d want %0d", i, starts_q[i+1] - starts_q[i], NB * DIV); else n_pass++;
    end
    n_checks++; if (starts_q.size() > 0 && fall - starts_q[0] != 4 * NB * DIV) $display("FAIL burst_activity: got %0d want %0d", fall - starts_q[0], 4 * NB * DIV); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (i >= rx_q.size() || rx_q[i] !== b[i]) $display("FAIL burst_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, b[i]); else n_pass++;
    end
    n_checks++; if (line_err != 0 || ready_err != 0) $display("FAIL burst_line_ready: line_err=%0d ready_err=%0d want 0/0", line_err, ready_err); else n_pass++;
  endtask

  task automatic test_overflow;
    logic r, r6; int a0, fall; bit ok;
    clear_model();
    a0 = acc;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'(i), r);
      if (i == 6) r6 = r;
    end
    step(1'b0, 8'h00, r);
    wait_idle(fall, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL ovf_drain: busy never fell"); else n_pass++;
    n_checks++; if (r6 !== 1'b0) $display("FAIL ovf_ready6: got %b want 0", r6); else n_pass++;
    n_checks++; if (acc - a0 != 5) $display("FAIL ovf_accept: got %0d want 5", acc - a0); else n_pass++;
    n_checks++; if (rx_q.size() != 5) $display("FAIL ovf_frames: got %0d want 5", rx_q.size()); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < 5; i++) begin
      n_checks++; if (rx_q[i] !== 8'(i + 1)) $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'(i + 1)); else n_pass++;
    end
    n_checks++; if (starts_q.size() > 0 && fall - starts_q[0] != 5 * NB * DIV) $display("FAIL ovf_activity: got %0d want %0d", fall - starts_q[0], 5 * NB * DIV); else n_pass++;
    n_checks++; if (line_err != 0 || ready_err != 0) $display("FAIL ovf_line_ready: line_err=%0d ready_err=%0d want 0/0", line_err, ready_err); else n_pass++;
  endtask

  task automatic test_enable_drop;
    logic r, r33; int a0, fall; bit ok;
    clear_model();
    a0 = acc;
    step(1'b1, 8'h11, r);
    step(1'b1, 8'h22, r);
    repeat (5) step(1'b0, 8'h00, r);
    tx_enable = 1'b0;
    step(1'b1, 8'h33, r33);
    step(1'b0, 8'h00, r);
    wait_idle(fall, ok);
    n_checks++; if (r33 !== 1'b0) $display("FAIL en_ready: got %b want 0", r33); else n_pass++;
    n_checks++; if (ok !== 1'b1) $display("FAIL en_drain: busy never fell"); else n_pass++;
    n_checks++; if (acc - a0 != 2) $display("FAIL en_accept: got %0d want 2", acc - a0); else n_pass++;
    n_checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) $display("FAIL en_data: got %0d bytes want 11 22", rx_q.size()); else n_pass++;
    n_checks++; if (line_err != 0 || ready_err != 0) $display("FAIL en_line_ready: line_err=%0d ready_err=%0d want 0/0", line_err, ready_err); else n_pass++;
    tx_enable = 1'b1;
    #1;
  endtask

  task automatic test_random;
    logic r; int fall, bad; bit ok;
    clear_model();
    for (int i = 0; i < 400; i++) begin
      tx_enable = ($urandom_range(0, 9) != 0);
      step(1'($urandom_range(0, 1)), 8'($urandom), r);
    end
    tx_enable = 1'b1;
    step(1'b0, 8'h00, r);
    wait_idle(fall, ok);
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    n_checks++; if (ok !== 1'b1) $display("FAIL rand_drain: busy never fell"); else n_pass++;
    n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d frames want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL rand_data: %0d wrong bytes want 0", bad); else n_pass++;
    n_checks++; if (line_err != 0 || ready_err != 0) $display("FAIL rand_line_ready: line_err=%0d ready_err=%0d want 0/0", line_err, ready_err); else n_pass++;
  endtask

  task automatic test_frame_length;
    logic r; int fall; bit ok;
    clear_model();
    step(1'b1, 8'h07, r);
    step(1'b1, 8'h03, r);
    step(1'b0, 8'h00, r);
    wait_idle(fall, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL len_drain: busy never fell"); else n_pass++;
    n_checks++; if (starts_q.size() != 2 || starts_q[1] - starts_q[0] != NB * DIV) $display("FAIL len_frame: frames=%0d want 2 spaced %0d", starts_q.size(), NB * DIV); else n_pass++;
    n_checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h07 || rx_q[1] !== 8'h03) $display("FAIL len_data: got %0d bytes want 07 03", rx_q.size()); else n_pass++;
`ifdef UART_TX_PARITY_EN
    n_checks++; if (par_q.size() != 2 || par_q[0] !== 1'b1 || par_q[1] !== 1'b0) $display("FAIL parity_bits: got %0d bits want 1 0", par_q.size()); else n_pass++;
`endif
    n_checks++; if (line_err != 0) $display("FAIL len_line: %0d bad bit cycles want 0", line_err); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    logic r; int st0, idle_err; bit found;
    clear_model();
    step(1'b1, 8'h5A, r);
    step(1'b1, 8'hC3, r);
    step(1'b1, 8'h3C, r);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mon_active && mon_cyc == 4 * DIV + 1) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 8'h00, r);
    end
    n_checks++; if (found !== 1'b1) $display("FAIL rstmid_reach_bit3: never reached"); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (txd !== 1'b1 || tx_busy !== 1'b0) $display("FAIL rstmid_async: txd=%b busy=%b want 1/0", txd, tx_busy); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", tx_ready); else n_pass++;
    exp_q.delete(); rx_q.delete(); par_q.delete();
    acc = started;
    st0 = started;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    idle_err = 0;
    for (int i = 0; i < 3 * NB * DIV; i++) begin
      @(negedge clk);
      #1;
      if (txd !== 1'b1 || tx_busy !== 1'b0) idle_err++;
    end
    n_checks++; if (idle_err != 0) $display("FAIL rstmid_idle: %0d non-idle cycles want 0", idle_err); else n_pass++;
    n_checks++; if (started != st0) $display("FAIL rstmid_frames: got %0d new frames want 0", started - st0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_enable_drop();
    test_frame_length();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
